// File: rtl/vector_lsu.sv
// Vector load/store unit: moves five 32-bit lanes between the vector register file and a strided memory region.
// One beat per cycle, done 6 cycles after start, 7 cycles per transfer; there is no backpressure, and start is ignored while busy.
module vector_lsu #(
   parameter int STRIDE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_load,
   input  logic [31:0] base_addr,
   input  logic [31:0] vec_in_0,
   input  logic [31:0] vec_in_1,
   input  logic [31:0] vec_in_2,
   input  logic [31:0] vec_in_3,
   input  logic [31:0] vec_in_4,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   output logic [31:0] vec_out_0,
   output logic [31:0] vec_out_1,
   output logic [31:0] vec_out_2,
   output logic [31:0] vec_out_3,
   output logic [31:0] vec_out_4,
   output logic        vec_we,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, STORE, LOAD, DONE} state_t;

   localparam logic [31:0] STRIDE_W = 32'(STRIDE);

   state_t      state;
   logic [2:0]  idx;
   logic [2:0]  next_idx;
   logic [31:0] base_q;
   logic [31:0] base_aligned;
   logic [31:0] next_addr;
   logic [31:0] snap     [0:4];
   logic [31:0] lane_buf [0:3];

   assign next_idx     = idx + 3'd1;
   assign base_aligned = base_addr & 32'hFFFF_FFFC;
   assign next_addr    = base_q + STRIDE_W * {29'd0, next_idx};

   // Outputs are registered: each branch loads the values for the cycle it is entering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         idx       <= 3'd0;
         base_q    <= 32'd0;
         for (int i = 0; i < 5; i++) snap[i] <= 32'd0;
         for (int i = 0; i < 4; i++) lane_buf[i] <= 32'd0;
         vec_out_0 <= 32'd0;
         vec_out_1 <= 32'd0;
         vec_out_2 <= 32'd0;
         vec_out_3 <= 32'd0;
         vec_out_4 <= 32'd0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         vec_we    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         vec_we <= 1'b0;
         done   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  base_q   <= base_aligned;
                  mem_addr <= base_aligned;
                  idx      <= 3'd0;
                  busy     <= 1'b1;
                  if (is_load) begin
                     state  <= LOAD;
                     mem_re <= 1'b1;
                  end else begin
                     state     <= STORE;
                     mem_we    <= 1'b1;
                     mem_wdata <= vec_in_0;
                     snap[0]   <= vec_in_0;
                     snap[1]   <= vec_in_1;
                     snap[2]   <= vec_in_2;
                     snap[3]   <= vec_in_3;
                     snap[4]   <= vec_in_4;
                  end
               end
            end
            STORE: begin
               if (idx == 3'd4) begin
                  state     <= DONE;
                  idx       <= 3'd0;
                  mem_we    <= 1'b0;
                  mem_addr  <= 32'd0;
                  mem_wdata <= 32'd0;
                  done      <= 1'b1;
               end else begin
                  idx       <= next_idx;
                  mem_addr  <= next_addr;
                  mem_wdata <= snap[next_idx];
               end
            end
            LOAD: begin
               if (idx == 3'd4) begin
                  // Lane 4 goes straight to the output; lanes 0..3 come from the buffer.
                  state     <= DONE;
                  idx       <= 3'd0;
                  mem_re    <= 1'b0;
                  mem_addr  <= 32'd0;
                  vec_out_0 <= lane_buf[0];
                  vec_out_1 <= lane_buf[1];
                  vec_out_2 <= lane_buf[2];
                  vec_out_3 <= lane_buf[3];
                  vec_out_4 <= mem_rdata;
                  vec_we    <= 1'b1;
                  done      <= 1'b1;
               end else begin
                  lane_buf[idx[1:0]] <= mem_rdata;
                  idx      <= next_idx;
                  mem_addr <= next_addr;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vector_lsu.sv
// Directed bench for vector_lsu: table of store/load transfers plus hand-written start-ignore and reset-abort sequences.
module tb_vector_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_load;
   logic [31:0] base_addr;
   logic [31:0] vec_in_0, vec_in_1, vec_in_2, vec_in_3, vec_in_4;
   logic [31:0] mem_rdata;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_we, mem_re;
   logic [31:0] vec_out_0, vec_out_1, vec_out_2, vec_out_3, vec_out_4;
   logic        vec_we, busy, done;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic            is_load;
      logic [31:0]     base;
      logic [4:0][31:0] addr;
      logic [4:0][31:0] data;
   } vec_t;

   vec_t             tbl [0:4];
   vec_t             post_reset;
   logic [4:0][31:0] last_vout;
   logic [31:0]      mem [logic [31:0]];

   vector_lsu #(.STRIDE(4)) dut (
      .clk(clk), .reset(reset), .start(start), .is_load(is_load), .base_addr(base_addr),
      .vec_in_0(vec_in_0), .vec_in_1(vec_in_1), .vec_in_2(vec_in_2), .vec_in_3(vec_in_3),
      .vec_in_4(vec_in_4), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_re(mem_re), .vec_out_0(vec_out_0), .vec_out_1(vec_out_1),
      .vec_out_2(vec_out_2), .vec_out_3(vec_out_3), .vec_out_4(vec_out_4), .vec_we(vec_we),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mrd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   // Memory model: writes on the rising edge, read data settles before the next edge.
   always @(posedge clk) if (mem_we) mem[mem_addr] = mem_wdata;
   always @(negedge clk) mem_rdata = mrd(mem_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_vin(input logic [4:0][31:0] d);
      vec_in_0 = d[0]; vec_in_1 = d[1]; vec_in_2 = d[2]; vec_in_3 = d[3]; vec_in_4 = d[4];
   endtask

   task automatic chk_vout(input string name, input logic [4:0][31:0] exp);
      chk({name, " lane0"}, vec_out_0, exp[0]);
      chk({name, " lane1"}, vec_out_1, exp[1]);
      chk({name, " lane2"}, vec_out_2, exp[2]);
      chk({name, " lane3"}, vec_out_3, exp[3]);
      chk({name, " lane4"}, vec_out_4, exp[4]);
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
   task automatic run_xfer(input vec_t v, input string name);
      if (v.is_load) for (int i = 0; i < 5; i++) mem[v.addr[i]] = v.data[i];
      start = 1'b1; is_load = v.is_load; base_addr = v.base;
      set_vin(v.is_load ? {5{32'hBAD0_BAD0}} : v.data);
      @(negedge clk);
      start = 1'b0;
      set_vin({5{32'hDEAD_BEEF}});
      base_addr = 32'h0000_9990;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk({name, " busy"}, 32'(busy), 32'd1);
         chk({name, " addr"}, mem_addr, v.addr[i]);
         chk({name, " we"}, 32'(mem_we), 32'(!v.is_load));
         chk({name, " re"}, 32'(mem_re), 32'(v.is_load));
         chk({name, " done early"}, 32'(done), 32'd0);
         if (!v.is_load) chk({name, " wdata"}, mem_wdata, v.data[i]);
      end
      @(negedge clk);
      chk({name, " done"}, 32'(done), 32'd1);
      chk({name, " busy in done"}, 32'(busy), 32'd1);
      chk({name, " vec_we"}, 32'(vec_we), 32'(v.is_load));
      chk({name, " we in done"}, 32'(mem_we), 32'd0);
      chk({name, " re in done"}, 32'(mem_re), 32'd0);
      chk({name, " addr in done"}, mem_addr, 32'd0);
      chk({name, " wdata in done"}, mem_wdata, 32'd0);
      if (v.is_load) last_vout = v.data;
      chk_vout({name, " vout"}, last_vout);
      @(negedge clk);
      chk({name, " idle busy"}, 32'(busy), 32'd0);
      chk({name, " idle done"}, 32'(done), 32'd0);
      chk({name, " idle vec_we"}, 32'(vec_we), 32'd0);
      if (!v.is_load) for (int i = 0; i < 5; i++) chk({name, " mem"}, mrd(v.addr[i]), v.data[i]);
   endtask

   initial begin
      tbl[0] = '{1'b0, 32'h0000_0100,
                 {32'h110, 32'h10C, 32'h108, 32'h104, 32'h100}, {32'd5, 32'd4, 32'd3, 32'd2, 32'd1}};
      tbl[1] = '{1'b1, 32'h0000_0200,
                 {32'h210, 32'h20C, 32'h208, 32'h204, 32'h200}, {32'hE, 32'hD, 32'hC, 32'hB, 32'hA}};
      tbl[2] = '{1'b0, 32'h0000_0200,
                 {32'h210, 32'h20C, 32'h208, 32'h204, 32'h200}, {32'h55, 32'h54, 32'h53, 32'h52, 32'h51}};
      tbl[3] = '{1'b0, 32'hFFFF_FFF7,
                 {32'h4, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFF4},
                 {32'hC0FF_EE04, 32'hC0FF_EE03, 32'hC0FF_EE02, 32'hC0FF_EE01, 32'hC0FF_EE00}};
      tbl[4] = '{1'b1, 32'hFFFF_FFFE,
                 {32'hC, 32'h8, 32'h4, 32'h0, 32'hFFFF_FFFC},
                 {32'h1111_0005, 32'h1111_0004, 32'h1111_0003, 32'h1111_0002, 32'h1111_0001}};
      post_reset = '{1'b1, 32'h0000_0601,
                 {32'h610, 32'h60C, 32'h608, 32'h604, 32'h600},
                 {32'h7777_0005, 32'h7777_0004, 32'h7777_0003, 32'h7777_0002, 32'h7777_0001}};
      last_vout = '0;

      reset = 1'b0; start = 1'b0; is_load = 1'b0; base_addr = 32'h0;
      set_vin({5{32'h0}});
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset we", 32'(mem_we), 32'd0);
      chk("reset re", 32'(mem_re), 32'd0);
      chk("reset vec_we", 32'(vec_we), 32'd0);
      chk("reset addr", mem_addr, 32'd0);
      chk_vout("reset vout", '0);
      reset = 1'b1;
      @(negedge clk);
      chk("idle busy", 32'(busy), 32'd0);

      for (int t = 0; t < 5; t++) run_xfer(tbl[t], $sformatf("vec%0d", t));

      // Start held high through a store while inputs change: first transfer keeps the captured
      // values, the second is only accepted after the IDLE cycle.
      start = 1'b1; is_load = 1'b0; base_addr = 32'h400;
      set_vin({32'h15, 32'h14, 32'h13, 32'h12, 32'h11});
      @(negedge clk);
      base_addr = 32'h800;
      set_vin({32'h25, 32'h24, 32'h23, 32'h22, 32'h21});
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("hold addr", mem_addr, 32'h400 + 32'(4 * i));
         chk("hold wdata", mem_wdata, 32'h11 + 32'(i));
      end
      @(negedge clk);
      chk("hold done", 32'(done), 32'd1);
      @(negedge clk);
      chk("hold idle busy", 32'(busy), 32'd0);
      chk("hold idle we", 32'(mem_we), 32'd0);
      @(negedge clk);
      start = 1'b0;
      chk("hold 2nd busy", 32'(busy), 32'd1);
      chk("hold 2nd addr", mem_addr, 32'h800);
      chk("hold 2nd wdata", mem_wdata, 32'h21);
      repeat (6) @(negedge clk);
      chk("hold 2nd idle", 32'(busy), 32'd0);
      chk("hold mem first", mrd(32'h410), 32'h15);
      chk("hold mem second", mrd(32'h810), 32'h25);
      chk_vout("hold vout", last_vout);

      // Reset during the idx=2 load beat.
      start = 1'b1; is_load = 1'b1; base_addr = 32'h200;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort addr", mem_addr, 32'h208);
      chk("abort re", 32'(mem_re), 32'd1);
      reset = 1'b0;
      #1;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort re off", 32'(mem_re), 32'd0);
      chk("abort vec_we", 32'(vec_we), 32'd0);
      chk_vout("abort vout", '0);
      @(negedge clk);
      reset = 1'b1;
      begin
         int pulses = 0;
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (vec_we || mem_we || done || busy) pulses++;
         end
         chk("abort quiet", 32'(pulses), 32'd0);
      end
      last_vout = '0;
      run_xfer(post_reset, "post reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
